// File: rtl/eth_speed_pkg.sv
// Shared encodings for the RGMII link-speed detector.
// Speed codes, measurement classes and detector FSM states.
package eth_speed_pkg;

    localparam logic [1:0] SPEED_10M  = 2'b00;
    localparam logic [1:0] SPEED_100M = 2'b01;
    localparam logic [1:0] SPEED_1G   = 2'b10;

    // Class codes share the speed encoding; 2'b11 means no clock seen.
    typedef enum logic [1:0] {
        CLASS_10M  = 2'b00,
        CLASS_100M = 2'b01,
        CLASS_1G   = 2'b10,
        CLASS_NONE = 2'b11
    } class_e;

    typedef enum logic {
        LINK_DOWN = 1'b0,
        LOCKED    = 1'b1
    } state_e;

endpackage

// File: rtl/eth_toggle_sync.sv
// Three-flop synchroniser for a slow toggle from another clock domain.
// Flags an edge whenever the last two synchronised samples differ.
module eth_toggle_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic edge_flag
);

    logic [2:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], din};
        end
    end

    assign edge_flag = sync[1] ^ sync[2];

endmodule

// File: rtl/eth_rgmii_speed_detect.sv
// RGMII link-speed detector: counts rx_toggle edges per gtx_clk window.
// Optional ETH_SPEED_FORCE_EN adds a software override of the outputs.
module eth_rgmii_speed_detect
    import eth_speed_pkg::*;
#(
    parameter int unsigned WINDOW_W    = 10,
    parameter int unsigned EDGE_W      = 9,
    parameter int unsigned THRESH_1G   = 128,
    parameter int unsigned THRESH_100M = 24,
    parameter int unsigned THRESH_10M  = 2,
    parameter int unsigned STABLE_CNT  = 3,
    parameter int unsigned LOSS_CNT    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_toggle,
`ifdef ETH_SPEED_FORCE_EN
    input  logic              cfg_force_en,
    input  logic [1:0]        cfg_force_speed,
`endif
    output logic [1:0]        speed,
    output logic              mii_select,
    output logic              link_up,
    output logic              speed_change,
    output logic [EDGE_W-1:0] last_edges
);

    localparam logic [3:0] STABLE = 4'(STABLE_CNT);
    localparam logic [3:0] LOSS   = 4'(LOSS_CNT);

    logic                edge_flag;
    logic                win_end;
    logic [WINDOW_W-1:0] win_cnt;
    logic [EDGE_W-1:0]   edge_cnt;
    logic [EDGE_W-1:0]   edge_fin;
    logic                ge_1g;
    logic                ge_100m;
    logic                ge_10m;
    class_e              cls;
    class_e              cand;
    class_e              cand_d;
    logic [3:0]          agree;
    logic [3:0]          agree_d;
    state_e              state;
    state_e              state_d;
    logic [1:0]          fsm_spd;
    logic [1:0]          spd_d;
    logic                fsm_lnk;
    logic                lnk_d;
    logic                chg_d;
    logic [1:0]          out_spd;
    logic                out_lnk;
    logic                out_chg;

    eth_toggle_sync u_rx_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (rx_toggle),
        .edge_flag (edge_flag)
    );

    assign win_end  = &win_cnt;
    // Final count includes an edge flagged on the window-end cycle.
    assign edge_fin = (edge_flag && !(&edge_cnt)) ? edge_cnt + 1'b1
                                                  : edge_cnt;

    assign ge_1g   = 32'(edge_fin) >= THRESH_1G;
    assign ge_100m = 32'(edge_fin) >= THRESH_100M;
    assign ge_10m  = 32'(edge_fin) >= THRESH_10M;

    always_comb begin
        cls = CLASS_NONE;
        unique case (1'b1)
            ge_1g:              cls = CLASS_1G;
            ge_100m && !ge_1g:  cls = CLASS_100M;
            ge_10m && !ge_100m: cls = CLASS_10M;
            default:            cls = CLASS_NONE;
        endcase
    end

    always_comb begin
        cand_d  = cls;
        agree_d = 4'd1;
        if (cls == cand) begin
            cand_d  = cand;
            agree_d = (agree == 4'hf) ? agree : agree + 4'd1;
        end
    end

    always_comb begin
        state_d = state;
        spd_d   = fsm_spd;
        lnk_d   = fsm_lnk;
        chg_d   = 1'b0;
        if (win_end) begin
            unique case (state)
                LINK_DOWN: begin
                    if (cand_d != CLASS_NONE && agree_d == STABLE) begin
                        spd_d   = cand_d;
                        lnk_d   = 1'b1;
                        chg_d   = 1'b1;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (cand_d == CLASS_NONE && agree_d == LOSS) begin
                        lnk_d   = 1'b0;
                        chg_d   = 1'b1;
                        state_d = LINK_DOWN;
                    end else if (cand_d != CLASS_NONE &&
                                 cand_d != class_e'(fsm_spd) &&
                                 agree_d == STABLE) begin
                        spd_d = cand_d;
                        chg_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ETH_SPEED_FORCE_EN
    logic       force_q;
    logic [1:0] force_spd_q;
    logic       force_evt;

    assign force_evt = (cfg_force_en != force_q) ||
                       (cfg_force_en && cfg_force_speed != force_spd_q);
    assign out_spd   = cfg_force_en ? cfg_force_speed : spd_d;
    assign out_lnk   = cfg_force_en || lnk_d;
    assign out_chg   = force_evt || (chg_d && !cfg_force_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            force_q     <= 1'b0;
            force_spd_q <= SPEED_1G;
        end else begin
            force_q     <= cfg_force_en;
            force_spd_q <= cfg_force_speed;
        end
    end
`else
    assign out_spd = spd_d;
    assign out_lnk = lnk_d;
    assign out_chg = chg_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt      <= '0;
            edge_cnt     <= '0;
            last_edges   <= '0;
            cand         <= CLASS_NONE;
            agree        <= '0;
            state        <= LINK_DOWN;
            fsm_spd      <= SPEED_1G;
            fsm_lnk      <= 1'b0;
            speed        <= SPEED_1G;
            mii_select   <= 1'b0;
            link_up      <= 1'b0;
            speed_change <= 1'b0;
        end else begin
            win_cnt      <= win_cnt + 1'b1;
            state        <= state_d;
            fsm_spd      <= spd_d;
            fsm_lnk      <= lnk_d;
            speed        <= out_spd;
            mii_select   <= ~out_spd[1];
            link_up      <= out_lnk;
            speed_change <= out_chg;
            if (win_end) begin
                last_edges <= edge_fin;
                edge_cnt   <= {{(EDGE_W-1){1'b0}}, edge_flag};
                cand       <= cand_d;
                agree      <= agree_d;
            end else begin
                edge_cnt <= edge_fin;
            end
        end
    end

endmodule

// File: tb/tb_eth_rgmii_speed_detect.sv
// Directed bench for eth_rgmii_speed_detect at default parameters.
// Window = 1024 cycles of an 8 ns clk; rx_toggle period set in ns.
module tb_eth_rgmii_speed_detect;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_toggle = 1'b0;
    logic [1:0] speed;
    logic       mii_select;
    logic       link_up;
    logic       speed_change;
    logic [8:0] last_edges;
`ifdef ETH_SPEED_FORCE_EN
    logic       cfg_force_en = 1'b0;
    logic [1:0] cfg_force_speed = 2'b00;
`endif

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int tog_ns = 32;
    bit tog_run = 1'b0;

    eth_rgmii_speed_detect dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_toggle       (rx_toggle),
`ifdef ETH_SPEED_FORCE_EN
        .cfg_force_en    (cfg_force_en),
        .cfg_force_speed (cfg_force_speed),
`endif
        .speed           (speed),
        .mii_select      (mii_select),
        .link_up         (link_up),
        .speed_change    (speed_change),
        .last_edges      (last_edges)
    );

    always #4 clk = ~clk;

    // Toggles land on negedges, well away from the sampling posedge.
    always begin
        #(tog_ns);
        if (tog_run) rx_toggle = ~rx_toggle;
    end

    always @(negedge clk) if (speed_change === 1'b1) pulses++;

    typedef struct {
        string nm;
        int    tog;
        bit    run;
        int    spd;
        int    mii;
        int    lnk;
        int    chg;
        int    elo;
        int    ehi;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string nm, input int act,
                       input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (250) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
    endtask

    initial begin
        vt[0] = '{"1g",     32,   1'b1, 2, 0, 1, 1, 256, 256};
        vt[1] = '{"100m",   160,  1'b1, 1, 1, 1, 1, 51,  52};
        vt[2] = '{"10m",    1600, 1'b1, 0, 1, 1, 1, 5,   6};
        vt[3] = '{"glitch", 8,    1'b1, 2, 0, 1, 1, 511, 511};
        vt[4] = '{"noclk",  32,   1'b0, 2, 0, 0, 0, 0,   0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_speed", speed, 2, 2);
        chk("rst_mii", mii_select, 0, 0);
        chk("rst_link", link_up, 0, 0);
        chk("rst_chg", speed_change, 0, 0);
        chk("rst_edges", last_edges, 0, 0);

        for (int i = 0; i < 5; i++) begin
            tog_ns  = vt[i].tog;
            tog_run = vt[i].run;
            do_reset();
            cyc(3071);
            chk({vt[i].nm, "_early_link"}, link_up, 0, 0);
            cyc(1);
            chk({vt[i].nm, "_link"}, link_up, vt[i].lnk, vt[i].lnk);
            chk({vt[i].nm, "_chg"}, speed_change, vt[i].chg, vt[i].chg);
            cyc(1);
            chk({vt[i].nm, "_chg_end"}, speed_change, 0, 0);
            chk({vt[i].nm, "_speed"}, speed, vt[i].spd, vt[i].spd);
            chk({vt[i].nm, "_mii"}, mii_select, vt[i].mii, vt[i].mii);
            chk({vt[i].nm, "_edges"}, last_edges, vt[i].elo, vt[i].ehi);
            cyc(50);
            chk({vt[i].nm, "_pulses"}, pulses, vt[i].chg, vt[i].chg);
        end

        // Clock loss after lock at 1000M.
        tog_ns = 32;
        tog_run = 1'b1;
        do_reset();
        cyc(3080);
        chk("loss_pre_link", link_up, 1, 1);
        pulses = 0;
        tog_run = 1'b0;
        cyc(3 * 1024);
        chk("loss_link", link_up, 0, 0);
        chk("loss_speed", speed, 2, 2);
        chk("loss_pulses", pulses, 1, 1);

        // A single stopped window must not disturb the lock.
        tog_run = 1'b1;
        do_reset();
        cyc(3080);
        pulses = 0;
        tog_run = 1'b0;
        cyc(1024);
        tog_run = 1'b1;
        cyc(4 * 1024);
        chk("blip_link", link_up, 1, 1);
        chk("blip_speed", speed, 2, 2);
        chk("blip_pulses", pulses, 0, 0);

        // 1000M to 100M needs three agreeing windows.
        do_reset();
        cyc(4090);
        pulses = 0;
        tog_ns = 160;
        cyc(2058);
        chk("sw_two_speed", speed, 2, 2);
        chk("sw_two_pulses", pulses, 0, 0);
        cyc(1020);
        chk("sw_speed", speed, 1, 1);
        chk("sw_mii", mii_select, 1, 1);
        chk("sw_chg", speed_change, 1, 1);
        chk("sw_link", link_up, 1, 1);
        cyc(4);
        chk("sw_pulses", pulses, 1, 1);

        // Asynchronous reset mid-window.
        cyc(300);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_speed", speed, 2, 2);
        chk("mid_rst_mii", mii_select, 0, 0);
        chk("mid_rst_link", link_up, 0, 0);
        chk("mid_rst_chg", speed_change, 0, 0);
        chk("mid_rst_edges", last_edges, 0, 0);

`ifdef ETH_SPEED_FORCE_EN
        tog_ns = 32;
        do_reset();
        cyc(3080);
        cfg_force_speed = 2'b00;
        cfg_force_en = 1'b1;
        cyc(1);
        chk("frc_speed", speed, 0, 0);
        chk("frc_mii", mii_select, 1, 1);
        chk("frc_link", link_up, 1, 1);
        chk("frc_chg", speed_change, 1, 1);
        cyc(1);
        chk("frc_chg_end", speed_change, 0, 0);
        cfg_force_speed = 2'b01;
        cyc(1);
        chk("frc_new_speed", speed, 1, 1);
        chk("frc_new_chg", speed_change, 1, 1);
        cfg_force_en = 1'b0;
        cyc(1);
        chk("frc_exit_speed", speed, 2, 2);
        chk("frc_exit_mii", mii_select, 0, 0);
        chk("frc_exit_chg", speed_change, 1, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_rgmii_speed_detect.md
Name: eth_rgmii_speed_detect

Overview:
Parametrised RGMII link-speed detector for the 1G MAC family, in the gtx_clk domain. Counts edges of a prescaled RX-clock toggle over a fixed reference window, classifies 10M/100M/1000M/no-clock, and commits a speed only after hysteresis. Adds link-loss detection, a change pulse and a status register. Drives speed and mii_select into rgmii_phy_if and the MAC mii_select synchronisers.

Parameters:
WINDOW_W, 10, reference window length = 2**WINDOW_W clk cycles.
EDGE_W, 9, edge counter width; counter saturates at 2**EDGE_W-1.
THRESH_1G, 128, edges per window at or above which the class is 1000M.
THRESH_100M, 24, edges at or above which the class is 100M (below THRESH_1G).
THRESH_10M, 2, edges at or above which the class is 10M (below THRESH_100M); fewer edges is class NONE.
STABLE_CNT, 3, consecutive identical non-NONE windows required to commit a speed (1..15).
LOSS_CNT, 2, consecutive NONE windows required to declare the link down (1..15).

Ports:
clk  in  1  reference clock (gtx_clk, 125 MHz).
rst_n  in  1  asynchronous active-low reset.
rx_toggle  in  1  asynchronous input: bit 2 of a free-running counter in the rx_clk domain.
speed  out  2  committed speed: 00 = 10M, 01 = 100M, 10 = 1000M.
mii_select  out  1  1 when speed is 10M or 100M.
link_up  out  1  a speed is committed and the clock is present.
speed_change  out  1  one-cycle pulse when speed or link_up changes.
last_edges  out  EDGE_W  edge count of the most recent completed window.

Behaviour:
- Reset values: speed = 2'b10; mii_select = 0; link_up = 0; speed_change = 0; last_edges = 0; all counters = 0; state = LINK_DOWN.
- rx_toggle passes through a 3-flop synchroniser. An edge is flagged when sync[1] differs from sync[2], giving 2 cycles of latency. Synchroniser flops reset to 0.
- Window counter (WINDOW_W bits) increments every cycle. The window ends on the cycle the counter is all-ones.
- Edge counter increments on each flagged edge and saturates.
- At window end:
  - last_edges receives the final count, including an edge flagged on the window-end cycle.
  - The edge counter clears to 0, or to 1 if an edge is flagged on the window-end cycle.
  - Class is computed from the final count using the thresholds; comparisons are unsigned.
- Candidate tracking, updated at window end only:
  - If class equals the candidate, agree_cnt increments, saturating at 15.
  - Otherwise candidate = class and agree_cnt = 1.
- FSM states:
  - LINK_DOWN: when the candidate is non-NONE and agree_cnt reaches STABLE_CNT, commit speed = candidate, set link_up = 1, pulse speed_change, go to LOCKED.
  - LOCKED, non-NONE candidate different from speed with agree_cnt = STABLE_CNT: commit the new speed and pulse speed_change; link_up stays 1.
  - LOCKED, NONE candidate with agree_cnt = LOSS_CNT: set link_up = 0, pulse speed_change, go to LINK_DOWN; speed holds its last value.
  - LOCKED, a single differing window: no output change.
- mii_select is registered and updates in the same cycle as speed, equal to ~speed[1].
- speed_change is high for exactly one cycle, on the cycle after the window-end evaluation.
- All outputs are registered, with no combinational paths from inputs.
- Reset asserted mid-window returns everything to reset values immediately. After release, the first commit occurs no earlier than STABLE_CNT full windows.
- A glitching rx_toggle (an edge every cycle) saturates the edge counter and classifies as 1000M.

Optional Feature:
Macro ETH_SPEED_FORCE_EN.
- When defined, adds ports cfg_force_en (in, 1) and cfg_force_speed (in, 2).
- While cfg_force_en = 1:
  - speed = cfg_force_speed, mii_select = ~cfg_force_speed[1], link_up = 1.
  - The outputs take effect on the next cycle.
  - speed_change pulses on entry, on exit, and whenever cfg_force_speed changes.
- Measurement continues in the background. On deassert, the outputs revert to the FSM's committed values.
- When undefined: no extra ports; behaviour is as above.

Decomposition:
- Package eth_speed_pkg:
  - speed encodings SPEED_10M = 2'b00, SPEED_100M = 2'b01, SPEED_1G = 2'b10;
  - class encoding (adds CLASS_NONE);
  - FSM state encoding LINK_DOWN/LOCKED.
- Sub-module eth_toggle_sync: 3-flop synchroniser plus edge flag, async active-low reset. It is reusable for the RX/TX mii_select synchronisers.

Test Plan:
- 125 MHz rx_clk, defaults → speed = 10, mii_select = 0, link_up = 1 after 3 windows (3072 cycles + sync latency); last_edges ≈ 256; one speed_change pulse.
- 25 MHz rx_clk → last_edges ≈ 51, speed = 01, mii_select = 1, link_up = 1 after 3 windows.
- 2.5 MHz rx_clk → last_edges of 5 ± 1, speed = 00, mii_select = 1.
- Locked at 1000M, rx_clk stopped → link_up = 0 after 2 NONE windows, speed holds 10, one pulse. A single stopped window followed by resumed clock → no output change.
- Locked at 1000M, switch to 25 MHz: two windows → no change; third window → speed = 01 with one pulse. Assert rst_n = 0 mid-window → all outputs at reset values within the same cycle.
- With ETH_SPEED_FORCE_EN defined, cfg_force_en = 1 and cfg_force_speed = 00 while locked at 1000M → speed = 00 and link_up = 1 next cycle, with a pulse. Deassert → speed = 10, with a pulse.
